// File: rtl/frame_buf_sched_if.sv
// Purpose: writer/reader handshake and memory-strobe bundle for frame_buf_sched.
// Latency: none, plain wires.
// Backpressure: wr_ready/rd_ready gate word transfer; a start request is dropped when no slot is available.
interface frame_buf_sched_if #(
    parameter int BUF_IDX_W  = 1,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_frame_start;
    logic                  wr_valid;
    logic                  wr_abort;
    logic                  wr_ready;
    logic [BUF_IDX_W-1:0]  wr_buf;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_mem_en;
    logic                  wr_start_miss;
    logic                  rd_frame_start;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [BUF_IDX_W-1:0]  rd_buf;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_mem_en;
    logic                  rd_start_miss;
    logic [BUF_IDX_W:0]    full_count;

    // Pixel source/sink side.
    modport master (
        output wr_frame_start, wr_valid, wr_abort, rd_frame_start, rd_valid,
        input  wr_ready, wr_buf, wr_addr, wr_mem_en, wr_start_miss,
        input  rd_ready, rd_buf, rd_addr, rd_mem_en, rd_start_miss, full_count
    );

    // Scheduler side.
    modport slave (
        input  wr_frame_start, wr_valid, wr_abort, rd_frame_start, rd_valid,
        output wr_ready, wr_buf, wr_addr, wr_mem_en, wr_start_miss,
        output rd_ready, rd_buf, rd_addr, rd_mem_en, rd_start_miss, full_count
    );
endinterface

// File: rtl/frame_buf_sched.sv
// Purpose: allocates frame slots to one writer and one reader, FIFO-orders completed frames, generates word addresses.
// Latency: grant visible one cycle after start; mem enables combinational from valid.
// Backpressure: start requests with no eligible slot are dropped with a one-cycle miss pulse; requester retries.
module frame_buf_sched #(
    parameter int NUM_BUFS   = 2,
    parameter int BUF_IDX_W  = 1,
    parameter int ADDR_WIDTH = 3
) (
    input logic               wr_clk,
    input logic               reset,
    frame_buf_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_FREE, S_WRITING, S_FULL, S_READING} slot_st_t;
    typedef enum logic {W_IDLE, W_FILL} wr_st_t;
    typedef enum logic {R_IDLE, R_READ} rd_st_t;

    slot_st_t              slot_st [NUM_BUFS];
    logic [BUF_IDX_W-1:0]  q_mem   [NUM_BUFS];
    logic [BUF_IDX_W-1:0]  q_head, q_tail;
    logic [BUF_IDX_W:0]    q_cnt;

    wr_st_t                wr_st;
    logic [BUF_IDX_W-1:0]  wr_buf_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_miss_q;
    rd_st_t                rd_st;
    logic [BUF_IDX_W-1:0]  rd_buf_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_miss_q;

    logic                  free_vld;
    logic [BUF_IDX_W-1:0]  free_idx;
    logic                  wr_grant, wr_drop, wr_done, rd_grant, rd_done;

    function automatic logic [BUF_IDX_W-1:0] ptr_inc(input logic [BUF_IDX_W-1:0] p);
        return (p == BUF_IDX_W'(NUM_BUFS - 1)) ? '0 : p + BUF_IDX_W'(1);
    endfunction

    // Lowest-index FREE slot, taken from registered state so a slot freed this cycle waits a cycle.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (slot_st[i] == S_FREE) begin
                free_vld = 1'b1;
                free_idx = BUF_IDX_W'(i);
            end
        end
    end

    // Slot lifecycle events; abort outranks the final word.
    assign wr_grant = (wr_st == W_IDLE) && bus.wr_frame_start && free_vld;
    assign wr_drop  = (wr_st == W_FILL) && bus.wr_abort;
    assign wr_done  = (wr_st == W_FILL) && !bus.wr_abort && bus.wr_valid && (&wr_addr_q);
    assign rd_grant = (rd_st == R_IDLE) && bus.rd_frame_start && (q_cnt != '0);
    assign rd_done  = (rd_st == R_READ) && bus.rd_valid && (&rd_addr_q);

    assign bus.wr_ready      = (wr_st == W_FILL);
    assign bus.wr_buf        = wr_buf_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_mem_en     = (wr_st == W_FILL) && bus.wr_valid && !bus.wr_abort;
    assign bus.wr_start_miss = wr_miss_q;
    assign bus.rd_ready      = (rd_st == R_READ);
    assign bus.rd_buf        = rd_buf_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.rd_mem_en     = (rd_st == R_READ) && bus.rd_valid;
    assign bus.rd_start_miss = rd_miss_q;
    assign bus.full_count    = q_cnt;

    // Writer FSM: claim a free slot, step the address per accepted word, release on last word or abort.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_st     <= W_IDLE;
            wr_buf_q  <= '0;
            wr_addr_q <= '0;
            wr_miss_q <= 1'b0;
        end else begin
            wr_miss_q <= 1'b0;
            case (wr_st)
                W_IDLE: begin
                    if (bus.wr_frame_start) begin
                        if (free_vld) begin
                            wr_buf_q  <= free_idx;
                            wr_addr_q <= '0;
                            wr_st     <= W_FILL;
                        end else begin
                            wr_miss_q <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (bus.wr_abort) begin
                        wr_addr_q <= '0;
                        wr_st     <= W_IDLE;
                    end else if (bus.wr_valid) begin
                        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                        if (&wr_addr_q) wr_st <= W_IDLE;
                    end
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end

    // Reader FSM: take the oldest completed slot, step the address per consumed word, free on last word.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            rd_st     <= R_IDLE;
            rd_buf_q  <= '0;
            rd_addr_q <= '0;
            rd_miss_q <= 1'b0;
        end else begin
            rd_miss_q <= 1'b0;
            case (rd_st)
                R_IDLE: begin
                    if (bus.rd_frame_start) begin
                        if (q_cnt != '0) begin
                            rd_buf_q  <= q_mem[q_head];
                            rd_addr_q <= '0;
                            rd_st     <= R_READ;
                        end else begin
                            rd_miss_q <= 1'b1;
                        end
                    end
                end
                R_READ: begin
                    if (bus.rd_valid) begin
                        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                        if (&rd_addr_q) rd_st <= R_IDLE;
                    end
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

    // Per-slot state; writer and reader events always target distinct slots.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFS; i++) slot_st[i] <= S_FREE;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (wr_grant && free_idx == BUF_IDX_W'(i))     slot_st[i] <= S_WRITING;
                if (wr_drop  && wr_buf_q == BUF_IDX_W'(i))     slot_st[i] <= S_FREE;
                if (wr_done  && wr_buf_q == BUF_IDX_W'(i))     slot_st[i] <= S_FULL;
                if (rd_grant && q_mem[q_head] == BUF_IDX_W'(i)) slot_st[i] <= S_READING;
                if (rd_done  && rd_buf_q == BUF_IDX_W'(i))     slot_st[i] <= S_FREE;
            end
        end
    end

    // Ready-queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            q_head <= '0;
            q_tail <= '0;
            q_cnt  <= '0;
        end else begin
            if (wr_done)  q_tail <= ptr_inc(q_tail);
            if (rd_grant) q_head <= ptr_inc(q_head);
            case ({wr_done, rd_grant})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Ready-queue storage; contents are meaningless while the count says empty, so no reset.
    always_ff @(posedge wr_clk) begin
        if (wr_done) q_mem[q_tail] <= wr_buf_q;
    end
endmodule

// File: tb/tb_frame_buf_sched.sv
// Purpose: directed bench for frame_buf_sched with a queue-based reference model checked every cycle.
// Latency: model advances on each rising edge; outputs compared on the falling edge.
// Backpressure: stimulus drives starts/valids directly; misses are expected where no slot is eligible.
module tb_frame_buf_sched;
    localparam int NB = 2;
    localparam int BW = 1;
    localparam int AW = 3;
    localparam int FL = 1 << AW;

    logic wr_clk = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    frame_buf_sched_if #(.BUF_IDX_W(BW), .ADDR_WIDTH(AW)) bus ();

    frame_buf_sched #(.NUM_BUFS(NB), .BUF_IDX_W(BW), .ADDR_WIDTH(AW)) dut (
        .wr_clk (wr_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 wr_clk = ~wr_clk;

    // Reference model: slot roles 0=free 1=writing 2=full 3=reading, completed slots in a queue.
    int m_slot [NB];
    int rq [$];
    bit m_wf, m_rf, m_wmiss, m_rmiss;
    int m_wbuf, m_waddr, m_rbuf, m_raddr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wr_clk) begin
        int lf;
        int n0;
        if (reset) begin
            for (int i = 0; i < NB; i++) m_slot[i] = 0;
            rq.delete();
            m_wf = 0; m_rf = 0; m_wmiss = 0; m_rmiss = 0;
            m_wbuf = 0; m_waddr = 0; m_rbuf = 0; m_raddr = 0;
        end else begin
            lf = -1;
            for (int i = NB - 1; i >= 0; i--) if (m_slot[i] == 0) lf = i;
            n0 = rq.size();
            m_wmiss = 0;
            m_rmiss = 0;
            if (!m_rf) begin
                if (bus.rd_frame_start) begin
                    if (n0 > 0) begin
                        m_rbuf = rq.pop_front();
                        m_slot[m_rbuf] = 3;
                        m_raddr = 0;
                        m_rf = 1;
                    end else m_rmiss = 1;
                end
            end else if (bus.rd_valid) begin
                if (m_raddr == FL - 1) begin
                    m_slot[m_rbuf] = 0;
                    m_rf = 0;
                end
                m_raddr = (m_raddr + 1) % FL;
            end
            if (!m_wf) begin
                if (bus.wr_frame_start) begin
                    if (lf >= 0) begin
                        m_wbuf = lf;
                        m_slot[lf] = 1;
                        m_waddr = 0;
                        m_wf = 1;
                    end else m_wmiss = 1;
                end
            end else if (bus.wr_abort) begin
                m_slot[m_wbuf] = 0;
                m_wf = 0;
            end else if (bus.wr_valid) begin
                if (m_waddr == FL - 1) begin
                    m_slot[m_wbuf] = 2;
                    rq.push_back(m_wbuf);
                    m_wf = 0;
                end
                m_waddr = (m_waddr + 1) % FL;
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge wr_clk) begin
        if (chk_on) begin
            chk("wr_ready", int'(bus.wr_ready), int'(m_wf));
            chk("wr_mem_en", int'(bus.wr_mem_en), int'(m_wf && bus.wr_valid && !bus.wr_abort));
            chk("wr_start_miss", int'(bus.wr_start_miss), int'(m_wmiss));
            chk("rd_ready", int'(bus.rd_ready), int'(m_rf));
            chk("rd_mem_en", int'(bus.rd_mem_en), int'(m_rf && bus.rd_valid));
            chk("rd_start_miss", int'(bus.rd_start_miss), int'(m_rmiss));
            chk("full_count", int'(bus.full_count), rq.size());
            if (m_wf) begin
                chk("wr_buf", int'(bus.wr_buf), m_wbuf);
                chk("wr_addr", int'(bus.wr_addr), m_waddr);
            end
            if (m_rf) begin
                chk("rd_buf", int'(bus.rd_buf), m_rbuf);
                chk("rd_addr", int'(bus.rd_addr), m_raddr);
            end
        end
    end

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_ready"}, int'(bus.wr_ready), 0);
        chk({tag, "_rd_ready"}, int'(bus.rd_ready), 0);
        chk({tag, "_full_count"}, int'(bus.full_count), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_wr_buf"}, int'(bus.wr_buf), 0);
        chk({tag, "_rd_buf"}, int'(bus.rd_buf), 0);
        chk({tag, "_wr_miss"}, int'(bus.wr_start_miss), 0);
        chk({tag, "_rd_miss"}, int'(bus.rd_start_miss), 0);
    endtask

    task automatic write_frame(input int exp_buf);
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("wf_grant_ready", int'(bus.wr_ready), 1);
        chk("wf_grant_buf", int'(bus.wr_buf), exp_buf);
        for (int i = 0; i < FL; i++) begin
            bus.wr_valid = 1'b1;
            #1;
            chk("wf_beat_addr", int'(bus.wr_addr), i);
            chk("wf_beat_en", int'(bus.wr_mem_en), 1);
            step();
        end
        bus.wr_valid = 1'b0;
        chk("wf_done_ready", int'(bus.wr_ready), 0);
    endtask

    task automatic read_frame(input int exp_buf);
        bus.rd_frame_start = 1'b1;
        step();
        bus.rd_frame_start = 1'b0;
        chk("rf_grant_ready", int'(bus.rd_ready), 1);
        chk("rf_grant_buf", int'(bus.rd_buf), exp_buf);
        for (int i = 0; i < FL; i++) begin
            bus.rd_valid = 1'b1;
            #1;
            chk("rf_beat_addr", int'(bus.rd_addr), i);
            chk("rf_beat_en", int'(bus.rd_mem_en), 1);
            step();
        end
        bus.rd_valid = 1'b0;
        chk("rf_done_ready", int'(bus.rd_ready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_frame_start = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_abort       = 1'b0;
        bus.rd_frame_start = 1'b0;
        bus.rd_valid       = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_on = 1'b1;
        chk_idle("reset");

        // First frame lands in slot 0, second in slot 1; store then full.
        write_frame(0);
        chk("one_full_count", int'(bus.full_count), 1);
        write_frame(1);
        chk("two_full_count", int'(bus.full_count), 2);

        // No free slot: one-cycle miss, no grant.
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("miss_pulse", int'(bus.wr_start_miss), 1);
        chk("miss_no_ready", int'(bus.wr_ready), 0);
        step();
        chk("miss_cleared", int'(bus.wr_start_miss), 0);
        chk("miss_still_idle", int'(bus.wr_ready), 0);

        // Frames come back oldest first.
        read_frame(0);
        chk("after_rd0_count", int'(bus.full_count), 1);
        read_frame(1);
        chk("after_rd1_count", int'(bus.full_count), 0);

        // Gapped write aborted at address 5.
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("ab_grant_buf", int'(bus.wr_buf), 0);
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            #1;
            chk("ab_beat_addr", int'(bus.wr_addr), i);
            step();
            bus.wr_valid = 1'b0;
            #1;
            chk("ab_gap_en", int'(bus.wr_mem_en), 0);
            step();
        end
        bus.wr_valid = 1'b1;
        bus.wr_abort = 1'b1;
        #1;
        chk("ab_addr5", int'(bus.wr_addr), 5);
        chk("ab_en_forced_off", int'(bus.wr_mem_en), 0);
        step();
        bus.wr_valid = 1'b0;
        bus.wr_abort = 1'b0;
        chk("ab_ready", int'(bus.wr_ready), 0);
        chk("ab_full_count", int'(bus.full_count), 0);
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("ab_regrant_buf", int'(bus.wr_buf), 0);
        chk("ab_regrant_addr", int'(bus.wr_addr), 0);

        // Reader start coinciding with the writer's last word misses; retry succeeds.
        for (int i = 0; i < FL - 1; i++) begin
            bus.wr_valid = 1'b1;
            step();
        end
        bus.rd_frame_start = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_frame_start = 1'b0;
        chk("sim_rd_miss", int'(bus.rd_start_miss), 1);
        chk("sim_rd_ready", int'(bus.rd_ready), 0);
        chk("sim_full_count", int'(bus.full_count), 1);
        bus.rd_frame_start = 1'b1;
        step();
        bus.rd_frame_start = 1'b0;
        chk("retry_rd_ready", int'(bus.rd_ready), 1);
        chk("retry_rd_buf", int'(bus.rd_buf), 0);
        chk("retry_full_count", int'(bus.full_count), 0);

        // Reset while both sides are mid-frame.
        for (int i = 0; i < 3; i++) begin
            bus.rd_valid = 1'b1;
            step();
        end
        bus.rd_valid = 1'b0;
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("mid_wr_buf", int'(bus.wr_buf), 1);
        chk("mid_rd_addr", int'(bus.rd_addr), 3);
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            step();
        end
        bus.wr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("midrst");
        bus.wr_frame_start = 1'b1;
        step();
        bus.wr_frame_start = 1'b0;
        chk("post_rst_ready", int'(bus.wr_ready), 1);
        chk("post_rst_buf", int'(bus.wr_buf), 0);
        chk("post_rst_addr", int'(bus.wr_addr), 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
Buffer scheduler for a multi-slot frame store. Each slot holds one frame of 2^ADDR_WIDTH words, and slots are shared between one frame writer and one frame reader.
- Allocates free slots to the writer and hands completed frames to the reader in completion order (oldest first).
- Generates per-slot word addresses and memory enables for both sides.
- Sits between the pixel source/sink and the data_mem instances; the slot index selects which data_mem is enabled.

Parameters:
NUM_BUFS, 2, number of frame slots (2..4)
BUF_IDX_W, 1, width of slot index; must satisfy 2^BUF_IDX_W >= NUM_BUFS
ADDR_WIDTH, 3, word address width; frame length = 2^ADDR_WIDTH words

Ports:
wr_clk  in  1  clock for all logic
reset  in  1  synchronous, active-high
wr_frame_start  in  1  writer requests a slot for a new frame
wr_valid  in  1  writer presents a word this cycle
wr_abort  in  1  writer discards the frame in progress
wr_ready  out  1  writer owns a slot (W_FILL)
wr_buf  out  BUF_IDX_W  slot being written
wr_addr  out  ADDR_WIDTH  word address within wr_buf
wr_mem_en  out  1  write strobe to the selected data_mem
wr_start_miss  out  1  one-cycle pulse: start requested with no FREE slot
rd_frame_start  in  1  reader requests a completed frame
rd_valid  in  1  reader consumes a word this cycle
rd_ready  out  1  reader owns a slot (R_READ)
rd_buf  out  BUF_IDX_W  slot being read
rd_addr  out  ADDR_WIDTH  word address within rd_buf
rd_mem_en  out  1  read strobe to the selected data_mem
rd_start_miss  out  1  one-cycle pulse: start requested with no FULL slot
full_count  out  BUF_IDX_W+1  number of slots in FULL state

Behaviour:
- Reset: applies only on a wr_clk edge with reset=1 and overrides every other input.
  - All slots FREE; ready queue empty.
  - Both FSMs idle.
  - wr_addr, rd_addr, wr_buf, rd_buf = 0.
  - wr_ready, rd_ready, wr_start_miss, rd_start_miss = 0; full_count = 0.
  - Reset in mid-frame discards all slot contents.
- Slot state: 2-bit register per slot, one of FREE, WRITING, FULL, READING. A slot is never granted to both sides at once.
- Ready queue:
  - FIFO of slot indices, depth NUM_BUFS, holding FULL slots in completion order.
  - full_count equals queue occupancy.
- Writer FSM states are W_IDLE and W_FILL.
  - W_IDLE with wr_frame_start=1 and at least one FREE slot: grant the lowest-index FREE slot → WRITING, set wr_buf, set wr_addr=0, go to W_FILL.
  - W_IDLE with wr_frame_start=1 and no FREE slot: pulse wr_start_miss next cycle and stay in W_IDLE. The request is not queued; the writer must retry.
  - W_FILL: wr_ready=1 and wr_mem_en = wr_valid (combinational).
  - W_FILL, each cycle with wr_valid=1: wr_addr increments.
  - W_FILL, wr_valid=1 with wr_addr = all ones: slot → FULL, index pushed to ready queue, wr_addr wraps to 0, go to W_IDLE.
  - W_FILL, wr_abort=1: slot → FREE, go to W_IDLE, and wr_mem_en is forced 0 that cycle. wr_abort takes priority over the last word.
  - wr_frame_start in W_FILL is ignored.
- Reader FSM states are R_IDLE and R_READ.
  - R_IDLE with rd_frame_start=1 and queue non-empty: pop the head slot → READING, set rd_buf, set rd_addr=0, go to R_READ.
  - R_IDLE with rd_frame_start=1 and queue empty: pulse rd_start_miss next cycle.
  - R_READ: rd_ready=1 and rd_mem_en = rd_valid.
  - R_READ, each cycle with rd_valid=1: rd_addr increments.
  - R_READ, rd_valid=1 with rd_addr = all ones: slot → FREE, go to R_IDLE.
- Latency: grant is visible (wr_ready/rd_ready=1) the cycle after the start request is sampled.
- Simultaneous events:
  - Writer completion and reader start in the same cycle: the newly FULL slot is not eligible until the next cycle. A reader start that sees an empty queue in that cycle misses.
  - Reader freeing a slot and writer start in the same cycle: the freed slot is not eligible until the next cycle.
  - Queue push and pop in the same cycle: occupancy is unchanged and order is preserved.
- Wrap-around: address counters wrap modulo 2^ADDR_WIDTH. Queue pointers wrap modulo NUM_BUFS.

Test Plan:
- Reset, then write 8 words (NUM_BUFS=2, ADDR_WIDTH=3) → wr_buf=0, wr_addr 0..7 with wr_mem_en each beat; then full_count=1 and wr_ready=0.
- Fill slots 0 and 1, then assert wr_frame_start → wr_start_miss pulses one cycle, wr_ready stays 0.
- Fill slot 0 then slot 1, then read twice → rd_buf=0 first, then 1; rd_addr 0..7 each frame; full_count ends at 0.
- Write with wr_valid gaps, then wr_abort at wr_addr=5 → slot 0 returns FREE and full_count=0; the next wr_frame_start regrants slot 0.
- rd_frame_start in the same cycle as the writer's last word → rd_start_miss=1; a retry next cycle grants that slot.
- Reset asserted mid-frame during both write and read → all outputs and full_count=0; a subsequent frame starts at slot 0, address 0.
